// File: rtl/sensor_sampler_ctrl.sv
// Periodic 4-channel sensor sequencer: triggers captures, packs 4x8-bit values into a FIFO, raises a fill-level irq.
// Optional capture timeout is compiled in when SENSOR_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module sensor_sampler_ctrl #(
    parameter int DEPTH    = 16,
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 16,
    parameter int TO_CYC   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic [PERIOD_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]       cfg_num,
    input  logic [$clog2(DEPTH):0] cfg_thresh,
    input  logic                   err_clr,
    output logic                   sensor_en,
    input  logic                   sensor_ready,
    input  logic [7:0]             sensor_out_0,
    input  logic [7:0]             sensor_out_1,
    input  logic [7:0]             sensor_out_2,
    input  logic [7:0]             sensor_out_3,
    input  logic                   rd_en,
    output logic [31:0]            rd_data,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   done,
    output logic                   irq,
    output logic                   overflow,
    output logic                   timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TO_CYC < 1) begin : g_param_check
        $error("sensor_sampler_ctrl: DEPTH must be a power of two >= 2 and TO_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, TRIG, CAPT, WAIT} state_t;

    state_t              state;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] wait_cnt;
    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    sample_cnt;
    logic [CNT_W-1:0]    sample_nxt;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   word;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          to_fire;

    assign word       = {sensor_out_3, sensor_out_2, sensor_out_1, sensor_out_0};
    assign push       = (state == CAPT) && sensor_ready;
    assign pop        = rd_en && (count != '0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok    = push && ((count != CW'(DEPTH)) || pop);
    assign drop       = push && !push_ok;
    assign count_next = count + CW'(push_ok) - CW'(pop);
    assign sample_nxt = sample_cnt + CNT_W'(1);

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign rd_data    = fifo_empty ? 32'h0 : mem[rd_ptr];
    assign busy       = (state != IDLE);

`ifdef SENSOR_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt;

    // Ready on the last allowed cycle still wins over the timeout.
    assign to_fire = (state == CAPT) && !sensor_ready && (to_cnt == TW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != CAPT) to_cnt <= '0;
        else                      to_cnt <= to_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)          timeout_err <= 1'b0;
        else if (to_fire) timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end
`else
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sensor_en  <= 1'b0;
            done       <= 1'b0;
            period_q   <= '0;
            num_q      <= '0;
            sample_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            sensor_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (cfg_en) begin
                    state      <= TRIG;
                    sensor_en  <= 1'b1;
                    sample_cnt <= '0;
                    period_q   <= cfg_period;
                    num_q      <= cfg_num;
                end
                TRIG: state <= CAPT;
                CAPT: if (push) begin
                    sample_cnt <= sample_nxt;
                    if (num_q != '0 && sample_nxt == num_q) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (!cfg_en) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= period_q;
                    end
                end else if (to_fire) begin
                    if (!cfg_en) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= period_q;
                    end
                end
                WAIT: if (!cfg_en) begin
                    state <= IDLE;
                end else if (wait_cnt == '0) begin
                    state     <= TRIG;
                    sensor_en <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt - PERIOD_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            irq      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            irq   <= (cfg_thresh != '0) && (count_next >= cfg_thresh);
            if (drop)         overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
        end
    end

    // NOTE: storage is deliberately not reset; the reset pointers and count make old words unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= word;
    end
endmodule

// File: tb/tb_sensor_sampler_ctrl.sv
// Randomised bench for sensor_sampler_ctrl against a queue-based FIFO model and a latency-driven sensor model.
`timescale 1ns/1ps
module tb_sensor_sampler_ctrl;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic [15:0]   cfg_period = '0;
    logic [15:0]   cfg_num = '0;
    logic [CW-1:0] cfg_thresh = '0;
    logic          err_clr = 1'b0;
    logic          sensor_en;
    logic          sensor_ready = 1'b0;
    logic [7:0]    sensor_out_0 = '0, sensor_out_1 = '0, sensor_out_2 = '0, sensor_out_3 = '0;
    logic          tb_rd = 1'b0, ready_pop = 1'b0;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic          fifo_empty, fifo_full, busy, done, irq, overflow, timeout_err;
    logic [CW-1:0] fifo_count;

    assign rd_en = tb_rd | ready_pop;

    sensor_sampler_ctrl #(.DEPTH(DEPTH), .PERIOD_W(16), .CNT_W(16), .TO_CYC(15)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_period(cfg_period), .cfg_num(cfg_num),
        .cfg_thresh(cfg_thresh), .err_clr(err_clr), .sensor_en(sensor_en), .sensor_ready(sensor_ready),
        .sensor_out_0(sensor_out_0), .sensor_out_1(sensor_out_1), .sensor_out_2(sensor_out_2),
        .sensor_out_3(sensor_out_3), .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .busy(busy), .done(done), .irq(irq),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Sensor model: answers each sensor_en pulse sens_lat cycles later (0 = never answers).
    int          sens_lat = 2;
    bit          fixed_data = 1'b0;
    bit          pop_on_ready = 1'b0;
    logic [31:0] sent[$];
    logic [31:0] w;

    initial begin
        forever begin
            @(posedge clk);
            if (sensor_en === 1'b1 && !rst && sens_lat > 0) begin
                repeat (sens_lat - 1) @(posedge clk);
                #1;
                w = fixed_data ? 32'h44332211 : $urandom;
                {sensor_out_3, sensor_out_2, sensor_out_1, sensor_out_0} = w;
                sent.push_back(w);
                sensor_ready = 1'b1;
                ready_pop    = pop_on_ready;
                @(posedge clk);
                #1;
                sensor_ready = 1'b0;
                ready_pop    = 1'b0;
            end
        end
    end

    // Reference FIFO: a queue plus a sticky overflow bit, updated from the bench's own stimulus.
    logic [31:0] mq[$];
    bit          m_ovf = 1'b0;
    bit          m_pop, m_lost;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = rd_en && mq.size() > 0;
            m_lost = 1'b0;
            if (sensor_ready) begin
                if (mq.size() < DEPTH || m_pop) mq.push_back({sensor_out_3, sensor_out_2, sensor_out_1, sensor_out_0});
                else m_lost = 1'b1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_lost) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sensor_en, busy, done, irq, overflow, timeout_err, fifo_empty, fifo_full} !== 8'b0000_0010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000010",
                     {sensor_en, busy, done, irq, overflow, timeout_err, fifo_empty, fifo_full});
        end
        checks++;
        if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c0, en_n = 0, en_cyc = -1, done_n = 0, done_cyc = -1;
        logic busy_at_done = 1'b1;
        fixed_data = 1'b1; cfg_num = 16'd1; cfg_period = 16'd5; cfg_thresh = '0;
        cfg_en = 1'b1; c0 = cyc;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sensor_en) begin en_n++; if (en_cyc < 0) en_cyc = cyc; cfg_en = 1'b0; end
            if (done) begin done_n++; done_cyc = cyc; busy_at_done = busy; end
        end
        fixed_data = 1'b0;
        checks++; if (en_n != 1) begin errors++; $display("FAIL single_en_pulses: got %0d expected 1", en_n); end
        checks++; if (en_cyc != c0 + 1) begin errors++; $display("FAIL single_en_latency: got %0d expected %0d", en_cyc - c0, 1); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_n); end
        checks++; if (done_cyc != en_cyc + 3) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", done_cyc, en_cyc + 3); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b expected 0", busy_at_done); end
        checks++; if (rd_data !== 32'h44332211) begin errors++; $display("FAIL single_rd_data: got %h expected 44332211", rd_data); end
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        tb_rd = 1'b1; @(negedge clk); tb_rd = 1'b0;
        checks++;
        if ({fifo_empty, rd_data} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL single_after_pop: got empty=%b data=%h expected empty=1 data=0", fifo_empty, rd_data);
        end
    endtask

    task automatic test_continuous();
        int last = -1, n_pulses = 0, extra_en = 0, extra_done = 0;
        bit got = 1'b0;
        cfg_num = '0; cfg_period = '0; cfg_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sensor_en) begin
                n_pulses++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 4) begin errors++; $display("FAIL cont_spacing: got %0d expected 4", cyc - last); end
                end
                last = cyc;
            end
        end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (sensor_en) begin got = 1'b1; n_pulses++; end
        end
        checks++; if (!got) begin errors++; $display("FAIL cont_wait_en: got no pulse expected pulse within 10 cycles"); end
        @(negedge clk);
        cfg_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sensor_en) extra_en++;
            if (done) extra_done++;
        end
        checks++; if (extra_en != 0 || extra_done != 0) begin errors++; $display("FAIL cont_stop: got en=%0d done=%0d expected 0 0", extra_en, extra_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy: got %b expected 0", busy); end
        checks++; if (fifo_count !== CW'(n_pulses)) begin errors++; $display("FAIL cont_count: got %0d expected %0d", fifo_count, n_pulses); end
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) begin
            checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL cont_drain_data: got %h expected %h", rd_data, mq[0]); end
            tb_rd = 1'b1; @(negedge clk); tb_rd = 1'b0;
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL cont_drained: got empty=%b expected 1", fifo_empty); end
    endtask

    task automatic test_overflow_irq();
        int en_n = 0;
        bit got_done = 1'b0;
        sent.delete();
        cfg_num = 16'd20; cfg_period = 16'($urandom_range(0, 3)); cfg_thresh = CW'(4);
        repeat (2) @(negedge clk);
        cfg_en = 1'b1;
        for (int i = 0; i < 400 && !got_done; i++) begin
            @(negedge clk);
            checks++;
            if (irq !== (mq.size() >= 4)) begin errors++; $display("FAIL ovf_irq: got %b expected %b at size %0d", irq, mq.size() >= 4, mq.size()); end
            if (sensor_en) en_n++;
            if (done) begin got_done = 1'b1; cfg_en = 1'b0; end
        end
        checks++; if (!got_done) begin errors++; $display("FAIL ovf_done: got no done expected done within 400 cycles"); end
        checks++; if (en_n != 20) begin errors++; $display("FAIL ovf_en_pulses: got %0d expected 20", en_n); end
        checks++; if ({fifo_full, overflow} !== 2'b11) begin errors++; $display("FAIL ovf_flags: got full=%b ovf=%b expected 1 1", fifo_full, overflow); end
        checks++; if (fifo_count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, DEPTH); end
        checks++; if (sent.size() == 0 || rd_data !== sent[0]) begin errors++; $display("FAIL ovf_head: got %h expected first sample", rd_data); end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        bit got_done = 1'b0;
        pop_on_ready = 1'b1;
        cfg_num = 16'd10; cfg_period = 16'($urandom_range(0, 3));
        cfg_en = 1'b1;
        for (int i = 0; i < 300 && !got_done; i++) begin
            @(negedge clk);
            checks++;
            if ({fifo_count, overflow} !== {CW'(DEPTH), 1'b0}) begin
                errors++; $display("FAIL b2b_full_pop: got count=%0d ovf=%b expected %0d 0", fifo_count, overflow, DEPTH);
            end
            if (done) begin got_done = 1'b1; cfg_en = 1'b0; end
        end
        pop_on_ready = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL b2b_done: got no done expected done within 300 cycles"); end
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) begin
            checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL b2b_order: got %h expected %h", rd_data, mq[0]); end
            tb_rd = 1'b1; @(negedge clk); tb_rd = 1'b0;
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_drained: got empty=%b expected 1", fifo_empty); end
    endtask

    task automatic test_random();
        int thr, rd_prob, tail;
        bit got_done;
        logic [31:0] exp_head;
        for (int r = 0; r < 6; r++) begin
            thr = $urandom_range(1, DEPTH); rd_prob = $urandom_range(0, 3);
            cfg_thresh = CW'(thr); cfg_num = 16'($urandom_range(1, 30)); cfg_period = 16'($urandom_range(0, 6));
            repeat (2) @(negedge clk);
            cfg_en = 1'b1; got_done = 1'b0; tail = 0;
            for (int c = 0; c < 800 && tail < 6; c++) begin
                @(negedge clk);
                exp_head = (mq.size() == 0) ? 32'h0 : mq[0];
                checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count: got %0d expected %0d", fifo_count, mq.size()); end
                checks++; if (rd_data !== exp_head) begin errors++; $display("FAIL rand_rd_data: got %h expected %h", rd_data, exp_head); end
                checks++; if (irq !== (mq.size() >= thr)) begin errors++; $display("FAIL rand_irq: got %b expected %b", irq, mq.size() >= thr); end
                checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow: got %b expected %b", overflow, m_ovf); end
                checks++;
                if ({fifo_empty, fifo_full} !== {mq.size() == 0, mq.size() == DEPTH}) begin
                    errors++; $display("FAIL rand_empty_full: got %b%b expected %b%b", fifo_empty, fifo_full, mq.size() == 0, mq.size() == DEPTH);
                end
                if (done) begin got_done = 1'b1; cfg_en = 1'b0; end
                if (got_done) tail++;
                tb_rd   = (rd_prob != 0) && ($urandom_range(0, rd_prob) == 0);
                err_clr = ($urandom_range(0, 15) == 0);
            end
            tb_rd = 1'b0; err_clr = 1'b0; cfg_en = 1'b0;
            checks++; if (!got_done) begin errors++; $display("FAIL rand_done: got no done expected done in run %0d", r); end
        end
        tb_rd = 1'b1;
        for (int i = 0; i < 2 * DEPTH && !fifo_empty; i++) @(negedge clk);
        tb_rd = 1'b0;
        @(negedge clk);
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rand_drained: got empty=%b expected 1", fifo_empty); end
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        int stray = 0;
        cfg_num = '0; cfg_period = 16'd8; cfg_thresh = CW'(2);
        cfg_en = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (mq.size() == 3) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL rmid_fill: got size %0d expected 3 within 200 cycles", mq.size()); end
        checks++; if ({busy, irq, fifo_count} !== {1'b1, 1'b1, CW'(3)}) begin errors++; $display("FAIL rmid_pre: got busy=%b irq=%b count=%0d expected 1 1 3", busy, irq, fifo_count); end
        rst = 1'b1; cfg_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sensor_en, busy, done, irq, overflow, timeout_err, fifo_empty, fifo_full} !== 8'b0000_0010) begin
            errors++;
            $display("FAIL rmid_flags: got %b expected 00000010",
                     {sensor_en, busy, done, irq, overflow, timeout_err, fifo_empty, fifo_full});
        end
        checks++;
        if ({fifo_count, rd_data} !== {CW'(0), 32'h0}) begin errors++; $display("FAIL rmid_fifo: got count=%0d data=%h expected 0 0", fifo_count, rd_data); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sensor_en || busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rmid_idle: got %0d active cycles expected 0", stray); end
    endtask

`ifdef SENSOR_TIMEOUT_EN
    task automatic test_timeout();
        int t_en = -1, t_to = -1, t_next = -1;
        sens_lat = 0; cfg_num = '0; cfg_period = 16'd3; cfg_thresh = '0;
        cfg_en = 1'b1;
        for (int i = 0; i < 10 && t_en < 0; i++) begin @(negedge clk); if (sensor_en) t_en = cyc; end
        for (int i = 0; i < 40 && t_to < 0; i++) begin @(negedge clk); if (timeout_err) t_to = cyc; end
        checks++; if (t_en < 0 || t_to != t_en + 16) begin errors++; $display("FAIL to_cycle: got %0d expected %0d", t_to - t_en, 16); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL to_count: got %0d expected 0", fifo_count); end
        for (int i = 0; i < 20 && t_next < 0; i++) begin
            if (sensor_en) t_next = cyc;
            else @(negedge clk);
        end
        cfg_en = 1'b0;
        checks++; if (t_next != t_to + 4) begin errors++; $display("FAIL to_next_en: got %0d expected %0d", t_next - t_to, 4); end
        repeat (25) @(negedge clk);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        checks++; if ({timeout_err, busy} !== 2'b00) begin errors++; $display("FAIL to_clear: got err=%b busy=%b expected 0 0", timeout_err, busy); end
        sens_lat = 2;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_overflow_irq();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SENSOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
